// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered result with zero/overflow flags behind a valid/ready handshake.
// Define ALU_MULU_EN to add the multi-cycle unsigned shift-add multiply on opcode 1000.
module alu_exec_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        aluctrl,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] result_hi,
  output logic              zero,
  output logic              overflow,
  output logic              busy
);
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_MUL = 2'd2} state_t;

  state_t state, state_nxt;
  logic   accept, is_mul, load_sc;

  assign accept  = in_valid && in_ready;
`ifdef ALU_MULU_EN
  assign is_mul  = (aluctrl == OP_MULU);
`else
  assign is_mul  = 1'b0;
`endif
  assign load_sc = accept && !is_mul;

  // Single-cycle datapath, evaluated directly on the incoming operands
  logic [DATA_W-1:0] sum, diff, sc_res;
  logic              sc_ovf;

  always_comb begin
    sum    = src_a + src_b;
    diff   = src_a - src_b;
    sc_res = '0;
    sc_ovf = 1'b0;
    case (aluctrl)
      OP_AND: sc_res = src_a & src_b;
      OP_OR:  sc_res = src_a | src_b;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (src_a[DATA_W-1] == src_b[DATA_W-1]) && (sum[DATA_W-1] != src_a[DATA_W-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (src_a[DATA_W-1] != src_b[DATA_W-1]) && (diff[DATA_W-1] != src_a[DATA_W-1]);
      end
      OP_SLT: sc_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_NOR: sc_res = ~(src_a | src_b);
      default: sc_res = '0;
    endcase
  end

`ifdef ALU_MULU_EN
  // Accumulator holds {partial product, remaining multiplier bits}
  logic [DATA_W-1:0]   mcand;
  logic [2*DATA_W-1:0] acc, acc_nxt;
  logic [DATA_W:0]     psum;
  logic [CNT_W-1:0]    cnt;
  logic                mul_last;

  assign psum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? mcand : {DATA_W{1'b0}})};
  assign acc_nxt  = {psum, acc[DATA_W-1:1]};
  assign mul_last = (state == S_MUL) && (cnt == CNT_W'(DATA_W-1));
  assign busy     = (state == S_MUL);
`else
  assign busy      = 1'b0;
  assign result_hi = '0;
`endif

  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_IDLE:  in_ready = 1'b1;
      S_HOLD:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign out_valid = (state == S_HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = is_mul ? S_MUL : S_HOLD;
      S_HOLD: if (out_ready) state_nxt = accept ? (is_mul ? S_MUL : S_HOLD) : S_IDLE;
`ifdef ALU_MULU_EN
      S_MUL:  if (mul_last) state_nxt = S_HOLD;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
`ifdef ALU_MULU_EN
      result_hi <= '0;
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
`endif
    end else begin
      if (load_sc) begin
        result   <= sc_res;
        zero     <= (sc_res == '0);
        overflow <= sc_ovf;
`ifdef ALU_MULU_EN
        result_hi <= '0;
`endif
      end
`ifdef ALU_MULU_EN
      if (accept && is_mul) begin
        mcand <= src_a;
        acc   <= {{DATA_W{1'b0}}, src_b};
        cnt   <= '0;
      end else if (state == S_MUL) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        if (mul_last) begin
          result    <= acc_nxt[DATA_W-1:0];
          result_hi <= acc_nxt[2*DATA_W-1:DATA_W];
          zero      <= (acc_nxt[DATA_W-1:0] == '0);
          overflow  <= 1'b0;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  aluctrl = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result, result_hi;
  logic        zero, overflow, busy;

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluctrl(aluctrl), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_hi(result_hi), .zero(zero),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef ALU_MULU_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  // Reference: signed/unsigned arithmetic on 64-bit integers
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [31:0] hi, output logic ov);
    longint sa, sb, s;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; hi = '0; ov = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin s = sa + sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0110: begin s = sa - sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      4'b1000: if (MUL_ON) begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; hi = p[63:32]; end
      default: r = '0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    return (MUL_ON && op == 4'b1000) ? 33 : 1;
  endfunction

  // Issue one op from IDLE, wait (bounded) for out_valid, leave DUT holding the result
  task automatic exec_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [31:0] h, output logic z,
                         output logic ov, output int lat, output int bcnt);
    aluctrl = op; src_a = a; src_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    aluctrl = 4'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    r = result; h = result_hi; z = zero; ov = overflow;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, result, result_hi, zero, overflow, busy} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got ov=%b r=%h hi=%h z=%b of=%b busy=%b rdy=%b, need all 0 with rdy=1",
               out_valid, result, result_hi, zero, overflow, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [31:0] r, h; logic z, ov; int lat, bc;
    exec_op(4'b0010, 32'h7FFF_FFFF, 32'h1, r, h, z, ov, lat, bc);
    checks++;
    if (lat !== 1 || r !== 32'h8000_0000 || ov !== 1'b1 || z !== 1'b0) begin
      errors++;
      $display("FAIL add_ovf: got lat=%0d r=%h ov=%b z=%b, need lat=1 r=80000000 ov=1 z=0", lat, r, ov, z);
    end
    release_out();
  endtask

  task automatic test_sub_slt();
    logic [31:0] r, h; logic z, ov; int lat, bc;
    exec_op(4'b0110, 32'h1234, 32'h1234, r, h, z, ov, lat, bc);
    checks++;
    if (r !== 32'h0 || z !== 1'b1 || ov !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL sub_zero: got r=%h z=%b ov=%b lat=%0d, need r=0 z=1 ov=0 lat=1", r, z, ov, lat);
    end
    release_out();
    exec_op(4'b0111, 32'hFFFF_FFFF, 32'h1, r, h, z, ov, lat, bc);
    checks++;
    if (r !== 32'h1 || z !== 1'b0) begin
      errors++;
      $display("FAIL slt_neg: got r=%h z=%b, need r=1 z=0", r, z);
    end
    release_out();
  endtask

  task automatic test_logic();
    logic [3:0]  ops [3]  = '{4'b1100, 4'b0000, 4'b0001};
    logic [31:0] as  [3]  = '{32'h0, 32'hFF00_FF00, 32'hF000_0000};
    logic [31:0] bs  [3]  = '{32'h0F0F_0F0F, 32'h0FF0_0FF0, 32'h0000_000F};
    logic [31:0] exp [3]  = '{32'hF0F0_F0F0, 32'h0F00_0F00, 32'hF000_000F};
    logic [31:0] r, h; logic z, ov; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      exec_op(ops[i], as[i], bs[i], r, h, z, ov, lat, bc);
      checks++;
      if (r !== exp[i] || lat !== 1 || ov !== 1'b0) begin
        errors++;
        $display("FAIL logic_%0d: got r=%h lat=%0d ov=%b, need r=%h lat=1 ov=0", i, r, lat, ov, exp[i]);
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [3:0]  pool [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0000};
    logic [3:0]  op;
    logic [31:0] a, b, r, h, er, eh;
    logic        z, ov, eov;
    int          lat, bc;
    for (int i = 0; i < 60; i++) begin
      op = (i % 7 == 6) ? 4'($urandom) : pool[$urandom_range(0, 5)];
      a  = $urandom;
      b  = (i % 5 == 0) ? a : $urandom;
      if (i % 9 == 0) begin a[31] = 1'b0; b[31] = 1'b1; end
      model(op, a, b, er, eh, eov);
      exec_op(op, a, b, r, h, z, ov, lat, bc);
      checks++;
      if (r !== er || h !== eh || z !== (er == 0) || ov !== eov || lat !== exp_lat(op)) begin
        errors++;
        $display("FAIL rand_%0d op=%b a=%h b=%h: got r=%h hi=%h z=%b ov=%b lat=%0d, need r=%h hi=%h z=%b ov=%b lat=%0d",
                 i, op, a, b, r, h, z, ov, lat, er, eh, (er == 0), eov, exp_lat(op));
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r, h; logic z, ov; int lat, bc;
    exec_op(4'b0010, 32'd100, 32'd23, r, h, z, ov, lat, bc);
    aluctrl = 4'b0001; src_a = 32'hDEAD_0000; src_b = 32'h0000_BEEF; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd123 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: got ov=%b r=%h rdy=%b, need ov=1 r=0000007b rdy=0", i, out_valid, result, in_ready);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got out_valid=%b, need 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (i <= 3) begin
        aluctrl = 4'b0010; src_a = 32'(i); src_b = 32'(i); in_valid = 1'b1;
      end else in_valid = 1'b0;
      if (i > 1) begin
        checks++;
        if (out_valid !== 1'b1 || result !== 32'(2 * (i - 1)) || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_%0d: got ov=%b r=%h rdy=%b, need ov=1 r=%h rdy=1", i - 1, out_valid, result, in_ready, 32'(2 * (i - 1)));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got out_valid=%b, need 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] a, b, r, h, er, eh; logic z, ov, eov; int lat, bc;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      b = (i == 0) ? 32'h2 : (i == 3 ? 32'h0 : $urandom);
      model(4'b1000, a, b, er, eh, eov);
      exec_op(4'b1000, a, b, r, h, z, ov, lat, bc);
      checks++;
      if (r !== er || h !== eh || z !== (er == 0) || ov !== 1'b0 || lat !== exp_lat(4'b1000) ||
          bc !== (MUL_ON ? 32 : 0)) begin
        errors++;
        $display("FAIL mul_%0d a=%h b=%h: got r=%h hi=%h z=%b ov=%b lat=%0d busy=%0d, need r=%h hi=%h z=%b ov=0 lat=%0d busy=%0d",
                 i, a, b, r, h, z, ov, lat, bc, er, eh, (er == 0), exp_lat(4'b1000), MUL_ON ? 32 : 0);
      end
      release_out();
    end
    // a non-multiply result must clear a prior high word
    exec_op(4'b0001, 32'h3, 32'h4, r, h, z, ov, lat, bc);
    checks++;
    if (r !== 32'h7 || h !== 32'h0) begin
      errors++;
      $display("FAIL hi_clear: got r=%h hi=%h, need r=00000007 hi=0", r, h);
    end
    release_out();
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] r, h; logic z, ov; int lat, bc;
    aluctrl = 4'b1000; src_a = 32'hFFFF_FFFF; src_b = 32'h3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, result, result_hi, zero, overflow, busy} !== '0) begin
      errors++;
      $display("FAIL mid_mul_reset: got ov=%b r=%h hi=%h z=%b of=%b busy=%b, need all 0",
               out_valid, result, result_hi, zero, overflow, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exec_op(4'b0010, 32'd5, 32'd7, r, h, z, ov, lat, bc);
    checks++;
    if (r !== 32'd12 || lat !== 1 || h !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_add: got r=%h lat=%0d hi=%h, need r=0000000c lat=1 hi=0", r, lat, h);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_logic();
    test_backpressure();
    test_back_to_back();
    test_mul();
    test_random();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
